// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing types for the video timing generator and receiver
package video_timing_pkg;
   localparam int H_CNT_W_DEF = 12;
   localparam int V_CNT_W_DEF = 11;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } vt_state_t;

   typedef struct packed {
      logic [H_CNT_W_DEF-1:0] h_total;
      logic [H_CNT_W_DEF-1:0] h_active;
      logic [V_CNT_W_DEF-1:0] v_total;
      logic [V_CNT_W_DEF-1:0] v_active;
   } timing_meas_t;
endpackage

// File: rtl/video_timing_rx_sync_edge.sv
// rtl/video_timing_rx_sync_edge.sv - pulse on the transition of a sync level into its active polarity
module sync_edge_det (
   input  logic pixel_clk,
   input  logic level,
   input  logic pol,
   output logic edge_pulse
);
   // Left unreset so the previous level tracks the line through reset and no false edge appears on release.
   logic level_q;

   always_ff @(posedge pixel_clk) begin
      level_q <= level;
   end

   assign edge_pulse = (level == pol) && (level_q != pol);
endmodule

// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - recovers sync polarity, frame geometry, pixel coordinates and lock from a video stream
module video_timing_rx
   import video_timing_pkg::*;
#(
   parameter int LOCK_FRAMES = 2,
   parameter int H_CNT_W     = H_CNT_W_DEF,
   parameter int V_CNT_W     = V_CNT_W_DEF
) (
   input  logic               pixel_clk,
   input  logic               rst_n,
   input  logic               h_sync_in,
   input  logic               v_sync_in,
   input  logic               de_in,
   output logic [10:0]        h_coord,
   output logic [9:0]         v_coord,
   output logic               pix_valid,
   output logic               h_pol_det,
   output logic               v_pol_det,
   output logic [H_CNT_W-1:0] h_total,
   output logic [H_CNT_W-1:0] h_active,
   output logic [V_CNT_W-1:0] v_total,
   output logic [V_CNT_W-1:0] v_active,
   output logic               frame_start,
   output logic               locked,
   output logic               timing_err
);
   localparam int MW = $clog2(LOCK_FRAMES + 1);

   logic h_r, v_r, de_r, de_q;
   logic de_rise, de_fall, h_edge, v_edge_raw, v_edge, timeout;
   logic pol_seen, started;
   logic [H_CNT_W-1:0] h_cnt, h_total_meas, h_active_meas;
   logic [V_CNT_W-1:0] line_cnt, de_line_cnt;
   timing_meas_t cur_meas, meas_q;
   vt_state_t state_q, state_d;
   logic [MW-1:0] match_q, match_d;
   logic locked_d, err_d;

   always_ff @(posedge pixel_clk) begin
      h_r  <= h_sync_in;
      v_r  <= v_sync_in;
      de_r <= de_in;
   end

   sync_edge_det u_h_edge (.pixel_clk(pixel_clk), .level(h_r), .pol(h_pol_det), .edge_pulse(h_edge));
   sync_edge_det u_v_edge (.pixel_clk(pixel_clk), .level(v_r), .pol(v_pol_det), .edge_pulse(v_edge_raw));

   assign de_rise = de_r & ~de_q;
   assign de_fall = ~de_r & de_q;
   // Frame boundaries only count once polarity has been learned from active video.
   assign v_edge  = v_edge_raw & pol_seen;
   assign timeout = &line_cnt;

   always_comb begin
      cur_meas.h_total  = H_CNT_W_DEF'(h_total_meas);
      cur_meas.h_active = H_CNT_W_DEF'(h_active_meas);
      cur_meas.v_total  = V_CNT_W_DEF'(line_cnt);
      cur_meas.v_active = V_CNT_W_DEF'(de_line_cnt);
   end

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      locked_d = locked;
      err_d    = 1'b0;
      if (timeout) begin
         state_d  = SEARCH;
         match_d  = '0;
         locked_d = 1'b0;
         err_d    = locked;
      end else if (v_edge && started) begin
         case (state_q)
            SEARCH: begin
               state_d = TRACK;
               match_d = MW'(1);
            end
            TRACK: begin
               if (cur_meas == meas_q) begin
                  match_d = match_q + 1'b1;
                  if (int'(match_q) + 1 >= LOCK_FRAMES) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = MW'(1);
               end
            end
            LOCKED: begin
               if (cur_meas != meas_q) begin
                  state_d  = TRACK;
                  match_d  = MW'(1);
                  locked_d = 1'b0;
                  err_d    = 1'b1;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         de_q          <= 1'b0;
         pix_valid     <= 1'b0;
         h_coord       <= '0;
         v_coord       <= '0;
         h_pol_det     <= 1'b1;
         v_pol_det     <= 1'b1;
         pol_seen      <= 1'b0;
         started       <= 1'b0;
         h_cnt         <= '0;
         h_total_meas  <= '0;
         h_active_meas <= '0;
         line_cnt      <= '0;
         de_line_cnt   <= '0;
         meas_q        <= '0;
         state_q       <= SEARCH;
         match_q       <= '0;
         locked        <= 1'b0;
         timing_err    <= 1'b0;
         frame_start   <= 1'b0;
      end else begin
         de_q        <= de_r;
         pix_valid   <= de_r;
         state_q     <= state_d;
         match_q     <= match_d;
         locked      <= locked_d;
         timing_err  <= err_d;
         frame_start <= v_edge;

         if (de_r) begin
            h_pol_det <= ~h_r;
            v_pol_det <= ~v_r;
            pol_seen  <= 1'b1;
         end

         // One counter serves both line period (sampled at DE rise) and DE run length (sampled at DE fall).
         if (de_rise)        h_cnt <= H_CNT_W'(1);
         else if (~&h_cnt)   h_cnt <= h_cnt + 1'b1;
         if (de_rise) h_total_meas  <= h_cnt;
         if (de_fall) h_active_meas <= h_cnt;

         if (de_rise)                 h_coord <= '0;
         else if (de_r && ~&h_coord)  h_coord <= h_coord + 1'b1;

         if (v_edge)                     v_coord <= '0;
         else if (de_fall && ~&v_coord)  v_coord <= v_coord + 1'b1;

         if (v_edge) begin
            line_cnt    <= h_edge ? V_CNT_W'(1) : '0;
            de_line_cnt <= '0;
         end else begin
            if (h_edge && ~&line_cnt)      line_cnt    <= line_cnt + 1'b1;
            if (de_fall && ~&de_line_cnt)  de_line_cnt <= de_line_cnt + 1'b1;
         end

         if (timeout)      started <= 1'b0;
         else if (v_edge)  started <= 1'b1;

         if (v_edge && started && !timeout) meas_q <= cur_meas;
      end
   end

   assign h_total  = H_CNT_W'(meas_q.h_total);
   assign h_active = H_CNT_W'(meas_q.h_active);
   assign v_total  = V_CNT_W'(meas_q.v_total);
   assign v_active = V_CNT_W'(meas_q.v_active);
endmodule

// File: tb/tb_video_timing_rx.sv
// tb/tb_video_timing_rx.sv - scoreboard bench for video_timing_rx
module tb_video_timing_rx;
   import video_timing_pkg::*;

   localparam int H_TOT = 40, H_ACT = 24, H_SYNC = 4, H_DE0 = 10;
   localparam int V_TOT = 20, V_ACT = 12, V_SYNC = 2, V_DE0 = 5;

   logic pixel_clk = 1'b0;
   logic rst_n = 1'b0;
   logic h_sync_in = 1'b0, v_sync_in = 1'b0, de_in = 1'b0;
   logic [10:0] h_coord;
   logic [9:0]  v_coord;
   logic pix_valid, h_pol_det, v_pol_det, frame_start, locked, timing_err;
   logic [11:0] h_total, h_active;
   logic [10:0] v_total, v_active;

   video_timing_rx dut (
      .pixel_clk(pixel_clk), .rst_n(rst_n),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
      .h_coord(h_coord), .v_coord(v_coord), .pix_valid(pix_valid),
      .h_pol_det(h_pol_det), .v_pol_det(v_pol_det),
      .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
      .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic        lk, er, pol;
      logic [11:0] ht, ha;
      logic [10:0] vt, va;
   } fs_rec_t;
   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
   } pix_rec_t;

   fs_rec_t  fsq[$];
   pix_rec_t pixq[$];
   int checks = 0, errors = 0, errp = 0;
   bit cc_en = 1'b0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_frame_start", frame_start, 0);
      check("rst_locked", locked, 0);
      check("rst_timing_err", timing_err, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_h_coord", h_coord, 0);
      check("rst_v_coord", v_coord, 0);
      check("rst_h_total", h_total, 0);
      check("rst_h_active", h_active, 0);
      check("rst_v_total", v_total, 0);
      check("rst_v_active", v_active, 0);
      check("rst_h_pol", h_pol_det, 1);
      check("rst_v_pol", v_pol_det, 1);
   endtask

   always @(negedge pixel_clk) begin
      pix_rec_t p;
      fs_rec_t  r;
      if (timing_err) errp++;
      if (pix_valid) begin
         if (pixq.size() > 0) begin
            p = pixq.pop_front();
            check("h_coord", h_coord, p.h);
            check("v_coord", v_coord, p.v);
         end else if (cc_en) begin
            check("pix_unexpected", pixq.size(), 1);
         end
      end
      if (frame_start) begin
         if (fsq.size() == 0) begin
            check("fs_unexpected", fsq.size(), 1);
         end else begin
            r = fsq.pop_front();
            check("fs_locked", locked, r.lk);
            check("fs_timing_err", timing_err, r.er);
            check("fs_h_pol", h_pol_det, r.pol);
            check("fs_v_pol", v_pol_det, r.pol);
            check("fs_h_total", h_total, r.ht);
            check("fs_h_active", h_active, r.ha);
            check("fs_v_total", v_total, r.vt);
            check("fs_v_active", v_active, r.va);
         end
      end
   end

   task automatic do_reset(bit inv);
      @(negedge pixel_clk);
      rst_n = 1'b0; h_sync_in = inv; v_sync_in = inv; de_in = 1'b0; cc_en = 1'b0;
      repeat (3) @(negedge pixel_clk);
      check_reset();
      rst_n = 1'b1;
   endtask

   task automatic send_line(bit inv, int ln, int h_act, bit cc, int rst_at);
      for (int c = 0; c < H_TOT; c++) begin
         @(negedge pixel_clk);
         if (rst_at >= 0 && c == rst_at + 3) begin
            check_reset();
            rst_n = 1'b1;
         end
         if (c == rst_at) rst_n = 1'b0;
         h_sync_in = inv ^ (c < H_SYNC);
         v_sync_in = inv ^ (ln < V_SYNC);
         de_in = (ln >= V_DE0) && (ln < V_DE0 + V_ACT) && (c >= H_DE0) && (c < H_DE0 + h_act);
         if (de_in && cc) pixq.push_back('{h: 11'(c - H_DE0), v: 10'(ln - V_DE0)});
      end
   endtask

   task automatic send_frame(bit inv, int h_act, bit fs, bit mv, int exp_ha, bit lk, bit er, bit cc, int rst_line);
      fs_rec_t r;
      cc_en = cc;
      if (fs) begin
         r.lk = lk; r.er = er; r.pol = ~inv;
         r.ht = mv ? 12'(H_TOT)  : 12'd0;
         r.ha = mv ? 12'(exp_ha) : 12'd0;
         r.vt = mv ? 11'(V_TOT)  : 11'd0;
         r.va = mv ? 11'(V_ACT)  : 11'd0;
         fsq.push_back(r);
      end
      for (int ln = 0; ln < V_TOT; ln++)
         send_line(inv, ln, h_act, cc, (ln == rst_line) ? 15 : -1);
   endtask

   task automatic send_idle(bit inv, int n);
      for (int l = 0; l < n; l++) begin
         for (int c = 0; c < 6; c++) begin
            @(negedge pixel_clk);
            h_sync_in = inv ^ (c < 2);
            v_sync_in = inv;
            de_in = 1'b0;
         end
      end
   endtask

   initial begin
      do_reset(1'b0);
      send_frame(0, 24, 0, 0, 0,  0, 0, 1, -1);
      send_frame(0, 24, 1, 0, 0,  0, 0, 1, -1);
      send_frame(0, 24, 1, 1, 24, 0, 0, 1, -1);
      send_frame(0, 24, 1, 1, 24, 1, 0, 1, -1);
      send_frame(0, 24, 1, 1, 24, 1, 0, 1, -1);

      do_reset(1'b1);
      send_frame(1, 24, 0, 0, 0,  0, 0, 1, -1);
      send_frame(1, 24, 1, 0, 0,  0, 0, 1, -1);
      send_frame(1, 24, 1, 1, 24, 0, 0, 1, -1);
      send_frame(1, 24, 1, 1, 24, 1, 0, 1, -1);
      send_frame(1, 24, 1, 1, 24, 1, 0, 1, -1);

      send_frame(1, 24, 1, 1, 24, 1, 0, 1, -1);
      send_frame(1, 23, 1, 1, 24, 1, 0, 1, -1);
      send_frame(1, 24, 1, 1, 23, 0, 1, 1, -1);
      send_frame(1, 24, 1, 1, 24, 0, 0, 1, -1);
      send_frame(1, 24, 1, 1, 24, 1, 0, 1, -1);

      cc_en = 1'b0;
      send_idle(1'b1, 2100);
      check("to_locked", locked, 0);
      check("to_state", dut.state_q, SEARCH);
      check("to_err_pulses", errp, 2);

      do_reset(1'b0);
      send_frame(0, 24, 0, 0, 0,  0, 0, 0, 6);
      send_frame(0, 24, 1, 0, 0,  0, 0, 1, -1);
      send_frame(0, 24, 1, 1, 24, 0, 0, 1, -1);
      send_frame(0, 24, 1, 1, 24, 1, 0, 1, -1);

      repeat (20) @(negedge pixel_clk);
      check("fs_pending", fsq.size(), 0);
      check("pix_pending", pixq.size(), 0);
      check("final_err_pulses", errp, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      checks++;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
